// File: rtl/dmem_pkg.sv
// Shared definitions for the IITB RISC data memory: FSM state encoding and
// Write_Read polarity constants also used by the pipeline control.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dmem_state_e;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

endpackage

// File: rtl/dmem_clear_ctrl.sv
// Post-reset clear sequencer: sweeps every word once, then opens the request
// port. Busy and Req_Ready are registered copies of the next state.
module dmem_clear_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  output logic             Busy,
  output logic             Req_Ready,
  output logic [CNT_W-1:0] Clear_Addr,
  output logic             Clear_We
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  dmem_state_e      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             busy_r, ready_r;

  // State, counter and registered status flags
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b1;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == ST_CLEAR);
      ready_r <= (state_s == ST_IDLE);
    end
  end

  // Next-state and next-count logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = ST_CLEAR;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = ST_CLEAR;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign Busy       = busy_r;
  assign Req_Ready  = ready_r;
  assign Clear_Addr = cnt_r;
  assign Clear_We   = busy_r;

endmodule

// File: rtl/data_memory_sync.sv
// Clocked data memory for the memory stage: valid/ready requests, byte-lane
// writes, one-cycle read latency and out-of-range flagging.
module data_memory_sync
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Req_Valid,
  output logic                    Req_Ready,
  input  logic                    Write_Read,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   Write_Data,
  input  logic [DATA_WIDTH/8-1:0] Byte_Enable,
  output logic                    Read_Valid,
  output logic [DATA_WIDTH-1:0]   Read_Data,
  output logic                    Addr_Error,
  output logic                    Busy
);

  localparam int                  LANES   = DATA_WIDTH / 8;
  localparam int                  CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] read_data_r, wr_word_s;
  logic                  read_valid_r, addr_error_r;
  logic                  accept_s, in_range_s, is_write_s, clear_we_s;
  logic [CNT_W-1:0]      word_idx_s, clear_addr_s;

  dmem_clear_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_clear_ctrl (
    .Clock      (Clock),
    .Reset      (Reset),
    .Busy       (Busy),
    .Req_Ready  (Req_Ready),
    .Clear_Addr (clear_addr_s),
    .Clear_We   (clear_we_s)
  );

  // Full-width compare so upper address bits can never alias into the array
  assign in_range_s = ({1'b0, Address} < DEPTH_W);
  assign accept_s   = Req_Valid & Req_Ready;
  assign is_write_s = (Write_Read == MEM_WRITE);
  assign word_idx_s = Address[CNT_W-1:0];

  // Byte-lane merge of store data into the currently stored word
  always_comb begin
    wr_word_s = mem_r[word_idx_s];
    for (int i = 0; i < LANES; i++) begin
      if (Byte_Enable[i]) begin
        wr_word_s[8*i +: 8] = Write_Data[8*i +: 8];
      end else begin
        wr_word_s[8*i +: 8] = mem_r[word_idx_s][8*i +: 8];
      end
    end
  end

  // Storage array: clear sweep has priority, then accepted in-range stores
  always_ff @(posedge Clock) begin
    if (clear_we_s) begin
      mem_r[clear_addr_s] <= {DATA_WIDTH{1'b0}};
    end else if (accept_s && is_write_s && in_range_s) begin
      mem_r[word_idx_s] <= wr_word_s;
    end
  end

  // Read result register and one-cycle status pulses
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      read_valid_r <= 1'b0;
      addr_error_r <= 1'b0;
      read_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      read_valid_r <= accept_s & ~is_write_s;
      addr_error_r <= accept_s & ~in_range_s;
      if (accept_s && !is_write_s) begin
        read_data_r <= in_range_s ? mem_r[word_idx_s] : {DATA_WIDTH{1'b0}};
      end
    end
  end

  assign Read_Valid = read_valid_r;
  assign Read_Data  = read_data_r;
  assign Addr_Error = addr_error_r;

endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync: directed plus random requests checked
// against an array-based reference model by an independent per-cycle monitor.
module tb_data_memory_sync;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Req_Valid = 1'b0;
  logic          Req_Ready;
  logic          Write_Read = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] Write_Data = '0;
  logic [1:0]    Byte_Enable = '0;
  logic          Read_Valid;
  logic [DW-1:0] Read_Data;
  logic          Addr_Error;
  logic          Busy;

  data_memory_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Req_Valid   (Req_Valid),
    .Req_Ready   (Req_Ready),
    .Write_Read  (Write_Read),
    .Address     (Address),
    .Write_Data  (Write_Data),
    .Byte_Enable (Byte_Enable),
    .Read_Valid  (Read_Valid),
    .Read_Data   (Read_Data),
    .Addr_Error  (Addr_Error),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int            cyc;
    logic          is_read;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_last = '0;
  logic          mon_en = 1'b0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  // Monitor: each cycle either a scheduled response or quiet, held outputs
  always @(negedge Clock) begin
    if (mon_en && !Reset) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        mon_e = sb_q.pop_front();
        check("read_valid", {31'd0, Read_Valid}, {31'd0, mon_e.is_read});
        check("addr_error", {31'd0, Addr_Error}, {31'd0, mon_e.err});
        if (mon_e.is_read) begin
          check("read_data", {16'd0, Read_Data}, {16'd0, mon_e.data});
          model_last = mon_e.data;
        end
      end else begin
        check("idle_read_valid", {31'd0, Read_Valid}, 32'd0);
        check("idle_addr_error", {31'd0, Addr_Error}, 32'd0);
        check("read_data_hold", {16'd0, Read_Data}, {16'd0, model_last});
      end
    end
  end

  // Drive one request for the coming edge; caller sits just after a posedge
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] be);
    exp_t e;
    Req_Valid   = 1'b1;
    Write_Read  = wr;
    Address     = a;
    Write_Data  = d;
    Byte_Enable = be;
    if (Req_Ready) begin
      e.cyc = cyc + 1;
      e.is_read = ~wr;
      e.err = (a >= AW'(DEPTH));
      e.data = '0;
      if (!e.err) begin
        if (wr) begin
          for (int i = 0; i < 2; i++)
            if (be[i]) model_mem[a[3:0]][8*i +: 8] = d[8*i +: 8];
        end else begin
          e.data = model_mem[a[3:0]];
        end
      end
      if (e.is_read || e.err) sb_q.push_back(e);
    end
    @(posedge Clock); #1;
    Req_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
    end
  endtask

  // Release reset and count edges until Req_Ready, with a request held
  task automatic sweep_and_count(input int limit, output int n);
    Req_Valid  = 1'b1;
    Write_Read = 1'b0;
    Address    = '0;
    Reset      = 1'b0;
    n = 0;
    while (!Req_Ready && n < limit) begin
      @(posedge Clock); #1;
      n++;
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  initial begin
    int n;
    #1 Reset = 1'b1;
    @(posedge Clock); #1;
    check("rst_req_ready", {31'd0, Req_Ready}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd1);
    check("rst_read_valid", {31'd0, Read_Valid}, 32'd0);
    check("rst_read_data", {16'd0, Read_Data}, 32'd0);
    check("rst_addr_error", {31'd0, Addr_Error}, 32'd0);
    @(posedge Clock); #1;
    mon_en = 1'b1;

    sweep_and_count(100, n);
    check("sweep_cycles", n, DEPTH);
    check("busy_after_sweep", {31'd0, Busy}, 32'd0);
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), '0, 2'b00);
    idle(2);

    // Full write, partial write, empty-mask write
    do_req(1'b1, 16'd5, 16'hBEEF, 2'b11);
    do_req(1'b0, 16'd5, '0, 2'b00);
    do_req(1'b1, 16'd5, 16'h1234, 2'b01);
    do_req(1'b0, 16'd5, '0, 2'b00);
    do_req(1'b1, 16'd5, 16'h5678, 2'b00);
    do_req(1'b0, 16'd5, '0, 2'b00);
    idle(2);

    // Out-of-range read and write; aliased word 3 must stay zero
    do_req(1'b0, 16'd16, '0, 2'b00);
    do_req(1'b1, 16'h8003, 16'hFFFF, 2'b11);
    do_req(1'b0, 16'd3, '0, 2'b00);
    idle(2);

    // Back-to-back reads, then held data
    do_req(1'b1, 16'd1, 16'hA1A1, 2'b11);
    do_req(1'b1, 16'd2, 16'hB2B2, 2'b11);
    do_req(1'b0, 16'd1, '0, 2'b00);
    do_req(1'b0, 16'd2, '0, 2'b00);
    do_req(1'b0, 16'd3, '0, 2'b00);
    idle(3);

    // Randomized traffic with idle gaps
    for (int k = 0; k < 300; k++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 9) == 0) a = 16'h8000 | AW'($urandom_range(0, 15));
      else a = AW'($urandom_range(0, 19));
      do_req(1'($urandom_range(0, 1)), a, DW'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(3);
    check("scoreboard_drained", sb_q.size(), 0);

    // Reset during the sweep restarts it from word 0
    @(posedge Clock); #1 Reset = 1'b1;
    sb_q.delete();
    model_last = '0;
    @(posedge Clock); #1;
    Req_Valid = 1'b1;
    Reset = 1'b0;
    idle(7);
    Reset = 1'b1;
    #1;
    check("midsweep_busy", {31'd0, Busy}, 32'd1);
    @(posedge Clock); #1;
    sweep_and_count(100, n);
    check("resweep_cycles", n, DEPTH);

    // Pending read pulse is dropped as soon as reset asserts
    do_req(1'b1, 16'd7, 16'hCAFE, 2'b11);
    do_req(1'b0, 16'd7, '0, 2'b00);
    check("pulse_before_reset", {31'd0, Read_Valid}, 32'd1);
    #1 Reset = 1'b1;
    #1;
    check("pulse_dropped", {31'd0, Read_Valid}, 32'd0);
    check("data_reset", {16'd0, Read_Data}, 32'd0);
    check("ready_reset", {31'd0, Req_Ready}, 32'd0);
    sb_q.delete();
    model_last = '0;
    @(posedge Clock); #1;
    sweep_and_count(100, n);
    check("final_sweep_cycles", n, DEPTH);
    do_req(1'b0, 16'd7, '0, 2'b00);
    idle(3);
    check("final_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_sync.md
# data_memory_sync

Clocked, parametrised data memory for the IITB RISC datapath, serving the memory stage of the pipeline. It accepts one read or write request per cycle through a valid/ready handshake and returns read data with fixed one-cycle latency. Byte-lane writes are supported, and out-of-range addresses are flagged. After reset, a sequential clear engine zeroes every word.

## Interface
- DATA_WIDTH, 16: word width in bits; multiple of 8.
- ADDR_WIDTH, 16: width of Address; word-addressed.
- DEPTH, 16: number of words; 2 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req_Valid  in  1  request present this cycle.
- Req_Ready  out  1  block can accept a request; low while clearing.
- Write_Read  in  1  1 = write, 0 = read (same polarity as existing memory).
- Address  in  ADDR_WIDTH  word address.
- Write_Data  in  DATA_WIDTH  store data.
- Byte_Enable  in  DATA_WIDTH/8  per-byte write mask; ignored on reads.
- Read_Valid  out  1  one-cycle pulse: Read_Data holds a fresh read result.
- Read_Data  out  DATA_WIDTH  last read result, held until next read completes.
- Addr_Error  out  1  one-cycle pulse: accepted request had Address ≥ DEPTH.
- Busy  out  1  clear sweep in progress.

## Operation
- Two-state FSM: CLEAR and IDLE.
- Reset asserted: the FSM is forced to CLEAR and the clear counter to 0, asynchronously.
- CLEAR state:
  - Each cycle with Reset low, write zero to Memory[counter] and increment the counter.
  - After writing word DEPTH-1, move to IDLE.
  - Req_Ready is 0 and Busy is 1.
- IDLE state: Req_Ready is 1 and Busy is 0. A request is accepted when Req_Valid && Req_Ready at a rising edge.
- Accepted write, in range: for each lane i with Byte_Enable[i]=1, Memory[Address][8i+7:8i] ← Write_Data[8i+7:8i]. Other lanes are unchanged.
  - Byte_Enable = 0 is accepted as a no-op.
  - No Read_Valid is produced.
- Accepted read, in range: Read_Data ← Memory[Address] and Read_Valid ← 1 for one cycle.
- Out-of-range request (Address ≥ DEPTH):
  - A write changes no memory.
  - A read returns Read_Data = 0 with Read_Valid pulsed.
  - Both set Addr_Error for one cycle.
- Request with Req_Valid high while Req_Ready is low: ignored entirely. It is not queued and no flags are raised; the requester must hold it.
- Read-after-write to the same address on consecutive accepted cycles returns the new data. No hazard exists because the write completes at the earlier edge.

## Timing
- Reset values: Req_Ready=0, Busy=1, Read_Valid=0, Read_Data=0, Addr_Error=0, FSM=CLEAR, counter=0.
- Memory contents are undefined until the sweep completes.
- Reset deasserted before edge 0: edges 0..DEPTH-1 clear words 0..DEPTH-1. Req_Ready rises after edge DEPTH-1, so the first request can be accepted at edge DEPTH.
- Read latency is 1: a read accepted at edge N gives Read_Valid=1 and valid Read_Data from edge N until edge N+1.
- Back-to-back reads give continuous Read_Valid.
- Addr_Error has the same timing as Read_Valid.
- Reset mid-sweep: the sweep restarts from word 0.
- Reset mid-operation: a pending Read_Valid/Addr_Error pulse is dropped and outputs return to reset values immediately.
- Counter width is $clog2(DEPTH). Its terminal compare is against DEPTH-1, so non-power-of-two depths never wrap into unowned indices.
- The range check compares the full ADDR_WIDTH address with DEPTH; upper address bits are never silently truncated.

## Structure
- Shared package dmem_pkg holds:
  - the FSM state encoding (CLEAR, IDLE);
  - the Write_Read polarity constants MEM_WRITE=1 and MEM_READ=0, reused by the pipeline control.
- One natural sub-module, dmem_clear_ctrl. It contains the FSM and clear counter, and outputs Busy, Req_Ready, the clear address and the clear write enable.
- The array, byte-lane write mux and read register stay in the top module.

## Test plan
- Reset pulse, then hold Req_Valid=1 → Req_Ready stays 0 for exactly 16 cycles after release, then rises; reading each address 0..15 returns 0x0000.
- Write 0xBEEF to address 5 with Byte_Enable=2'b11, then read 5 on the next cycle → Read_Data=0xBEEF with one Read_Valid pulse, one cycle after acceptance.
- Starting from 0xBEEF at address 5, write 0x1234 with Byte_Enable=2'b01, then read → 0xBE34; write with Byte_Enable=2'b00 → still 0xBE34.
- Read of address 16, then write 0xFFFF to address 0x8003 → Addr_Error pulses each time, the read returns 0, and address 3 is still 0.
- Reads of addresses 1, 2 and 3 on consecutive cycles → Read_Valid stays high for 3 cycles with matching data; the previous Read_Data is held afterwards.
- Reset asserted at sweep count 7 and released → the full 16-cycle sweep repeats; a pending read pulse is cleared immediately on reset.
